// File: rtl/fifo_rd_packer.sv
// Read-side FIFO consumer: packs PACK_RATIO bytes (lane 0 = first byte) into one word on a valid/ready stream.
// Optional PACKER_FLUSH_EN adds a flush input and out_bytes lane count for emitting partial words.
module fifo_rd_packer #(
   parameter int DATA_WIDTH = 8,
   parameter int PACK_RATIO = 2,
   parameter int CNT_WIDTH  = 4
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic                             fifo_empty,
   output logic                             fifo_rd_en,
   input  logic [DATA_WIDTH-1:0]            fifo_data,
   output logic [DATA_WIDTH*PACK_RATIO-1:0] out_data,
   output logic                             out_valid,
   input  logic                             out_ready,
`ifdef PACKER_FLUSH_EN
   input  logic                             flush,
   output logic [CNT_WIDTH-1:0]             out_bytes,
`endif
   output logic [CNT_WIDTH-1:0]             byte_cnt
);

   localparam int WW = DATA_WIDTH * PACK_RATIO;
   localparam logic [CNT_WIDTH:0]   RATIO_EXT = (CNT_WIDTH+1)'(PACK_RATIO);
   localparam logic [CNT_WIDTH-1:0] RATIO     = CNT_WIDTH'(PACK_RATIO);
   localparam logic [CNT_WIDTH-1:0] LAST_LANE = CNT_WIDTH'(PACK_RATIO - 1);

   localparam logic [0:0] ST_FILL = 1'b0;
   localparam logic [0:0] ST_HOLD = 1'b1;

   logic [0:0]           state;
   logic                 rd_pend;
   logic [WW-1:0]        acc;
   logic [WW-1:0]        acc_next;
   logic [CNT_WIDTH:0]   committed;
   logic                 out_free;
   logic                 xfer;
   logic                 last_cap;
   logic                 load_full;
   logic                 flush_hold;
   logic                 flush_fire;

   assign committed = {1'b0, byte_cnt} + (CNT_WIDTH+1)'(rd_pend);
   assign out_free  = ~out_valid | out_ready;
   assign xfer      = out_valid & out_ready;
   assign last_cap  = (state == ST_FILL) && rd_pend && (byte_cnt == LAST_LANE);
   assign load_full = (last_cap && out_free) || ((state == ST_HOLD) && xfer);

`ifdef PACKER_FLUSH_EN
   logic flush_req;

   // A flush that cannot fire immediately is remembered until the output frees.
   assign flush_hold = (flush | flush_req) && (state == ST_FILL) &&
                       (byte_cnt != '0) && !rd_pend;
   assign flush_fire = flush_hold && out_free;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flush_req <= 1'b0;
         out_bytes <= '0;
      end else begin
         flush_req <= (flush_req | (flush && ((byte_cnt != '0) || rd_pend))) &&
                      !flush_fire && !last_cap;
         if (load_full)
            out_bytes <= RATIO;
         else if (flush_fire)
            out_bytes <= byte_cnt;
      end
   end
`else
   assign flush_hold = 1'b0;
   assign flush_fire = 1'b0;
`endif

   assign fifo_rd_en = ~fifo_empty && (state == ST_FILL) &&
                       (committed < RATIO_EXT) && !flush_hold;

   always_comb begin
      acc_next = acc;
      if (rd_pend) begin
         for (int unsigned i = 0; i < PACK_RATIO; i++) begin
            if (byte_cnt == CNT_WIDTH'(i))
               acc_next[i*DATA_WIDTH +: DATA_WIDTH] = fifo_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_FILL;
         rd_pend   <= 1'b0;
         acc       <= '0;
         out_data  <= '0;
         out_valid <= 1'b0;
         byte_cnt  <= '0;
      end else begin
         rd_pend <= fifo_rd_en;
         case (state)
            ST_FILL: begin
               if (last_cap) begin
                  if (out_free) begin
                     out_data  <= acc_next;
                     out_valid <= 1'b1;
                     byte_cnt  <= '0;
                     acc       <= '0;
                  end else begin
                     acc      <= acc_next;
                     byte_cnt <= RATIO;
                     state    <= ST_HOLD;
                  end
               end else if (flush_fire) begin
                  // Upper lanes are zero because acc is cleared on every load.
                  out_data  <= acc;
                  out_valid <= 1'b1;
                  byte_cnt  <= '0;
                  acc       <= '0;
               end else begin
                  if (rd_pend) begin
                     acc      <= acc_next;
                     byte_cnt <= byte_cnt + CNT_WIDTH'(1);
                  end
                  if (xfer)
                     out_valid <= 1'b0;
               end
            end
            default: begin
               if (xfer) begin
                  out_data <= acc;
                  byte_cnt <= '0;
                  acc      <= '0;
                  state    <= ST_FILL;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: behavioural FIFO, word collector and a byte-order reference model.
module tb_fifo_rd_packer;

   localparam int DW = 8;
   localparam int PR = 2;
   localparam int CW = 4;
   localparam int OW = DW * PR;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [DW-1:0] fifo_data = '0;
   logic [OW-1:0] out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [CW-1:0] byte_cnt;
`ifdef PACKER_FLUSH_EN
   logic          flush = 1'b0;
   logic [CW-1:0] out_bytes;
`endif

   logic [DW-1:0] mem [0:255];
   int            wr_ptr = 0;
   int            rd_ptr = 0;
   logic          gate_empty = 1'b0;

   logic [OW-1:0] got_q [$];
   logic [CW-1:0] got_b [$];
   logic [DW-1:0] exp_bytes [$];

   int n_checks = 0;
   int n_fail   = 0;

   fifo_rd_packer #(.DATA_WIDTH(DW), .PACK_RATIO(PR), .CNT_WIDTH(CW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .fifo_empty (fifo_empty),
      .fifo_rd_en (fifo_rd_en),
      .fifo_data  (fifo_data),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
`ifdef PACKER_FLUSH_EN
      .flush      (flush),
      .out_bytes  (out_bytes),
`endif
      .byte_cnt   (byte_cnt)
   );

   always #5 clk = ~clk;

   // FIFO model: data_out registered one cycle after an accepted read.
   assign fifo_empty = (wr_ptr == rd_ptr) || gate_empty;

   always @(posedge clk) begin
      if (fifo_rd_en && !fifo_empty) begin
         fifo_data <= mem[rd_ptr % 256];
         rd_ptr    <= rd_ptr + 1;
      end
   end

   // Collector: a word sampled valid&ready here transfers on the next rising edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         got_q.push_back(out_data);
`ifdef PACKER_FLUSH_EN
         got_b.push_back(out_bytes);
`else
         got_b.push_back(CW'(PR));
`endif
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [DW-1:0] b);
      mem[wr_ptr % 256] = b;
      wr_ptr = wr_ptr + 1;
      exp_bytes.push_back(b);
   endtask

   task automatic clear_model();
      exp_bytes.delete();
      got_q.delete();
      got_b.delete();
   endtask

   // Word idx of the byte stream: byte idx*PR+k goes to lane k; missing lanes are zero.
   function automatic logic [OW-1:0] model_word(input int idx);
      logic [OW-1:0] w;
      w = '0;
      for (int k = 0; k < PR; k++) begin
         if (idx * PR + k < exp_bytes.size())
            w[k*DW +: DW] = exp_bytes[idx * PR + k];
      end
      return w;
   endfunction

   task automatic test_reset();
      rst_n = 1'b0;
      #3;
      n_checks++;
      if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
      n_checks++;
      if (out_data !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
      n_checks++;
      if (byte_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", byte_cnt); end
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", fifo_rd_en); end
      tick(2);
      rst_n = 1'b1;
      tick(1);
   endtask

   task automatic test_stream_ready();
      int rd_cycles = 0;
      int v_cycles  = 0;
      clear_model();
      out_ready = 1'b1;
      for (int i = 1; i <= 4; i++) push(DW'(i));
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (fifo_rd_en) rd_cycles++;
         if (out_valid) v_cycles++;
         @(posedge clk);
         #1;
      end
      n_checks++;
      if (rd_cycles != 4) begin n_fail++; $display("FAIL stream_rd_count: got %0d want 4", rd_cycles); end
      n_checks++;
      if (v_cycles != 2) begin n_fail++; $display("FAIL stream_valid_cycles: got %0d want 2", v_cycles); end
      n_checks++;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL stream_words: got %0d want 2", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 2; i++) begin
         n_checks++;
         if (got_q[i] !== model_word(i)) begin
            n_fail++; $display("FAIL stream_word%0d: got %h want %h", i, got_q[i], model_word(i));
         end
      end
      n_checks++;
      if (byte_cnt !== '0) begin n_fail++; $display("FAIL stream_cnt_end: got %0d want 0", byte_cnt); end
   endtask

   task automatic test_backpressure();
      clear_model();
      out_ready = 1'b0;
      for (int i = 1; i <= 4; i++) push(DW'(i));
      tick(10);
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== model_word(0)) begin
         n_fail++; $display("FAIL bp_held: got v=%b d=%h want v=1 d=%h", out_valid, out_data, model_word(0));
      end
      n_checks++;
      if (byte_cnt !== CW'(PR)) begin n_fail++; $display("FAIL bp_cnt: got %0d want %0d", byte_cnt, PR); end
      n_checks++;
      if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", fifo_rd_en); end
      n_checks++;
      if (wr_ptr - rd_ptr != 0) begin n_fail++; $display("FAIL bp_fifo_level: got %0d want 0", wr_ptr - rd_ptr); end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (out_data !== model_word(0)) begin n_fail++; $display("FAIL bp_before_release: got %h want %h", out_data, model_word(0)); end
      @(negedge clk);
      n_checks++;
      if (out_valid !== 1'b1 || out_data !== model_word(1)) begin
         n_fail++; $display("FAIL bp_next_word: got v=%b d=%h want v=1 d=%h", out_valid, out_data, model_word(1));
      end
      tick(4);
      n_checks++;
      if (got_q.size() != 2) begin n_fail++; $display("FAIL bp_words: got %0d want 2", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 2; i++) begin
         n_checks++;
         if (got_q[i] !== model_word(i)) begin
            n_fail++; $display("FAIL bp_word%0d: got %h want %h", i, got_q[i], model_word(i));
         end
      end
   endtask

   task automatic test_partial();
      clear_model();
      out_ready = 1'b1;
      push(8'h05);
      tick(8);
      n_checks++;
      if (byte_cnt !== CW'(1) || out_valid !== 1'b0) begin
         n_fail++; $display("FAIL partial_wait: got cnt=%0d v=%b want cnt=1 v=0", byte_cnt, out_valid);
      end
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL partial_no_out: got %0d words want 0", got_q.size()); end
      push(8'h06);
      tick(8);
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++; $display("FAIL partial_words: got %0d want 1", got_q.size());
      end else if (got_q[0] !== model_word(0)) begin
         n_fail++; $display("FAIL partial_word: got %h want %h", got_q[0], model_word(0));
      end
   endtask

   task automatic test_reset_mid();
      clear_model();
      out_ready = 1'b0;
      push(8'h07);
      push(8'h08);
      tick(8);
      push(8'h09);
      tick(6);
      n_checks++;
      if (byte_cnt !== CW'(1) || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL rstmid_pre: got cnt=%0d v=%b want cnt=1 v=1", byte_cnt, out_valid);
      end
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || out_data !== '0 || byte_cnt !== '0 || fifo_rd_en !== 1'b0) begin
         n_fail++; $display("FAIL rstmid_async: got v=%b d=%h cnt=%0d rd=%b want all 0",
                            out_valid, out_data, byte_cnt, fifo_rd_en);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      clear_model();
      out_ready = 1'b1;
      push(8'h10);
      push(8'h11);
      tick(8);
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++; $display("FAIL rstmid_words: got %0d want 1", got_q.size());
      end else if (got_q[0] !== model_word(0)) begin
         n_fail++; $display("FAIL rstmid_word: got %h want %h", got_q[0], model_word(0));
      end
   endtask

   task automatic test_toggle_empty();
      clear_model();
      for (int i = 0; i < 8; i++) push(DW'(8'h20 + i));
      for (int c = 0; c < 80; c++) begin
         gate_empty = ~gate_empty;
         out_ready  = 1'($urandom % 2);
         tick(1);
      end
      gate_empty = 1'b0;
      out_ready  = 1'b1;
      tick(12);
      n_checks++;
      if (got_q.size() != 4) begin n_fail++; $display("FAIL toggle_words: got %0d want 4", got_q.size()); end
      for (int i = 0; i < got_q.size() && i < 4; i++) begin
         n_checks++;
         if (got_q[i] !== model_word(i)) begin
            n_fail++; $display("FAIL toggle_word%0d: got %h want %h", i, got_q[i], model_word(i));
         end
      end
   endtask

   task automatic test_random();
      int pushed = 0;
      int nbytes = 40;
      clear_model();
      for (int c = 0; c < 2000 && (pushed < nbytes || c < 200); c++) begin
         if (pushed < nbytes && ($urandom % 2) == 1) begin
            push(DW'($urandom));
            pushed++;
         end
         gate_empty = (($urandom % 4) == 0);
         out_ready  = (($urandom % 3) != 0);
         tick(1);
      end
      gate_empty = 1'b0;
      out_ready  = 1'b1;
      tick(20);
      n_checks++;
      if (got_q.size() != nbytes / PR) begin
         n_fail++; $display("FAIL random_words: got %0d want %0d", got_q.size(), nbytes / PR);
      end
      for (int i = 0; i < got_q.size() && i < nbytes / PR; i++) begin
         n_checks++;
         if (got_q[i] !== model_word(i)) begin
            n_fail++; $display("FAIL random_word%0d: got %h want %h", i, got_q[i], model_word(i));
         end
      end
      n_checks++;
      if (byte_cnt !== '0) begin n_fail++; $display("FAIL random_cnt_end: got %0d want 0", byte_cnt); end
   endtask

`ifdef PACKER_FLUSH_EN
   task automatic test_flush();
      clear_model();
      out_ready = 1'b1;
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(3);
      n_checks++;
      if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_empty_ignored: got %0d words want 0", got_q.size()); end
      push(8'h33);
      tick(6);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(4);
      n_checks++;
      if (got_q.size() != 1) begin
         n_fail++; $display("FAIL flush_words: got %0d want 1", got_q.size());
      end else begin
         n_checks++;
         if (got_q[0] !== model_word(0) || got_b[0] !== CW'(1)) begin
            n_fail++; $display("FAIL flush_word: got %h/%0d want %h/1", got_q[0], got_b[0], model_word(0));
         end
      end
      n_checks++;
      if (byte_cnt !== '0) begin n_fail++; $display("FAIL flush_cnt: got %0d want 0", byte_cnt); end

      clear_model();
      out_ready = 1'b0;
      push(8'h44);
      push(8'h55);
      tick(8);
      push(8'h66);
      tick(6);
      flush = 1'b1;
      tick(1);
      flush = 1'b0;
      tick(4);
      n_checks++;
      if (out_data !== model_word(0) || byte_cnt !== CW'(1)) begin
         n_fail++; $display("FAIL flush_busy_hold: got %h cnt=%0d want %h cnt=1", out_data, byte_cnt, model_word(0));
      end
      out_ready = 1'b1;
      tick(6);
      n_checks++;
      if (got_q.size() != 2) begin
         n_fail++; $display("FAIL flush_busy_words: got %0d want 2", got_q.size());
      end else begin
         n_checks++;
         if (got_q[0] !== model_word(0) || got_b[0] !== CW'(PR)) begin
            n_fail++; $display("FAIL flush_busy_w0: got %h/%0d want %h/%0d", got_q[0], got_b[0], model_word(0), PR);
         end
         n_checks++;
         if (got_q[1] !== model_word(1) || got_b[1] !== CW'(1)) begin
            n_fail++; $display("FAIL flush_busy_w1: got %h/%0d want %h/1", got_q[1], got_b[1], model_word(1));
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_stream_ready();
      test_backpressure();
      test_partial();
      test_reset_mid();
      test_toggle_empty();
      test_random();
`ifdef PACKER_FLUSH_EN
      test_flush();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_rd_packer.md
Name: fifo_rd_packer

Overview:
- Read-side consumer of the 8-bit synchronous FIFO.
- Drains bytes through the FIFO's rd_en/data_out/empty interface and packs PACK_RATIO consecutive bytes into one word.
- Presents each word on a valid/ready output stream to the next stage.
- Absorbs the FIFO's one-cycle read latency and downstream backpressure without losing or duplicating bytes.

Parameters:
- DATA_WIDTH, 8: FIFO byte width.
- PACK_RATIO, 2: bytes per output word; legal values 2..8.
- CNT_WIDTH, 4: width of the byte counter; must satisfy 2^CNT_WIDTH > PACK_RATIO.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- fifo_empty  input  1  FIFO empty flag.
- fifo_rd_en  output  1  FIFO read enable.
- fifo_data  input  DATA_WIDTH  FIFO data_out; valid the cycle after rd_en was sampled high with empty low.
- out_data  output  DATA_WIDTH*PACK_RATIO  packed word.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  downstream accepts the word.
- byte_cnt  output  CNT_WIDTH  bytes held in the accumulator (debug).

Behaviour:
- One clock; reset is asynchronous and active-low (clk, rst_n). Assertion of rst_n=0 immediately clears every register.

Reset values:
- fifo_rd_en=0, out_valid=0, out_data=0, byte_cnt=0.
- Accumulator cleared, rd_pend=0, state=FILL.

Read issue:
- rd_pend is a register equal to last cycle's fifo_rd_en & ~fifo_empty.
- fifo_rd_en is combinational: fifo_rd_en = ~fifo_empty & (state==FILL) & (byte_cnt + rd_pend < PACK_RATIO). At most PACK_RATIO bytes are ever committed.
- Back-to-back reads are allowed.

Capture:
- Each edge with rd_pend=1 captures fifo_data into byte lane byte_cnt; byte_cnt increments.
- Lane 0 = LSBs, so the first byte read ends up in out_data[7:0].

State machine:
- FILL: accumulate bytes.
  - At the edge that captures lane PACK_RATIO-1, if the output register is free (out_valid=0, or out_ready=1), load {fifo_data, acc} straight into out_data. Set out_valid=1, byte_cnt=0, stay in FILL. This gives zero bubble.
  - Otherwise move to HOLD with byte_cnt=PACK_RATIO.
- HOLD: fifo_rd_en=0.
  - When the output register frees (out_valid & out_ready), load the accumulator into out_data on that edge, keep out_valid=1, set byte_cnt=0, go to FILL.

Output handshake:
- A transfer occurs on an edge where out_valid & out_ready.
- out_data and out_valid are stable while out_valid=1 and out_ready=0.
- out_valid drops after a transfer only if no new word is loaded on the same edge.

Latency and throughput:
- First byte read to out_valid: PACK_RATIO cycles with a non-empty FIFO.
- Sustained rate: one word per PACK_RATIO cycles.

Boundary conditions:
- FIFO going empty mid-word: the partial word waits indefinitely; byte_cnt is held and nothing is output.
- fifo_empty asserting while rd_pend=1: the in-flight byte is still captured.
- out_ready high with out_valid low: no effect.

Optional Feature:
- Macro PACKER_FLUSH_EN.
- When defined:
  - Adds input flush (1-bit) and output out_bytes (CNT_WIDTH), the number of valid lanes in out_data.
  - flush=1 sampled in FILL with byte_cnt>0 and rd_pend=0: fifo_rd_en is forced low that cycle.
  - The partial word goes out zero-padded in the upper lanes with out_bytes=byte_cnt, then byte_cnt=0. The output register must be free; otherwise the request is held until it is.
  - flush with byte_cnt=0 is ignored.
  - Full words report out_bytes=PACK_RATIO.
- When undefined: no flush/out_bytes ports; partial words are retained until completed.

Test Plan:
- PACK_RATIO=2, FIFO preloaded 0x01..0x04, out_ready=1 -> fifo_rd_en high 4 consecutive cycles; out_data 0x0201 then 0x0403, each with a single out_valid pulse; byte_cnt returns to 0.
- Same preload, out_ready=0 -> out_valid=1, out_data=0x0201 held; state HOLD with byte_cnt=2; fifo_rd_en=0; FIFO still holds 0 bytes and nothing is lost. Raise out_ready -> 0x0403 follows the next cycle.
- FIFO holds a single byte 0x05 -> byte_cnt=1, out_valid stays 0. Write 0x06 -> out_data=0x0605 emitted.
- Assert rst_n=0 while byte_cnt=1 and out_valid=1 -> all outputs 0 immediately. After release, fresh bytes 0x10,0x11 produce 0x1110 with no stale data.
- FIFO toggles empty every cycle while writing 0x20..0x27, out_ready random -> words 0x2120, 0x2322, 0x2524, 0x2726 in order; no duplicates or drops.
- PACKER_FLUSH_EN, single byte 0x33 then flush pulse -> out_data=0x0033, out_bytes=1, byte_cnt=0.
